// File: rtl/jogador_automatico.sv
// Auto-player for the memory game: replays the round/move press pattern on jogar/botoes,
// with optional single-move error injection and abort on end of game.
module jogador_automatico #(
    parameter int N_RODADAS     = 16,
    parameter int JOGAR_CICLOS  = 5,
    parameter int ESPERA_CICLOS = 10,
    parameter int HOLD_CICLOS   = 5,
    parameter int GAP_CICLOS    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fim_jogo,
    input  logic       erro_habilita,
    input  logic [3:0] erro_rodada,
    input  logic [3:0] erro_jogada,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic [3:0] rodada,
    output logic [3:0] jogada,
    output logic       ocupado,
    output logic       pronto
);
    localparam int MAX_AB = (JOGAR_CICLOS > ESPERA_CICLOS) ? JOGAR_CICLOS : ESPERA_CICLOS;
    localparam int MAX_CD = (HOLD_CICLOS > GAP_CICLOS) ? HOLD_CICLOS : GAP_CICLOS;
    localparam int MAX_C  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [3:0] ULTIMA = 4'(N_RODADAS - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIA,
        ESPERA,
        PRESSIONA,
        SOLTA,
        FIM
    } estado_t;

    estado_t       estado, estado_prox;
    logic [CW-1:0] cnt, cnt_prox;
    logic [3:0]    rodada_prox, jogada_prox;
    logic          err_en, err_en_prox;
    logic [3:0]    err_rod, err_rod_prox;
    logic [3:0]    err_jog, err_jog_prox;
    logic [3:0]    normal;
    logic          injeta;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
            cnt     <= '0;
            rodada  <= '0;
            jogada  <= '0;
            err_en  <= 1'b0;
            err_rod <= '0;
            err_jog <= '0;
        end else begin
            estado  <= estado_prox;
            cnt     <= cnt_prox;
            rodada  <= rodada_prox;
            jogada  <= jogada_prox;
            err_en  <= err_en_prox;
            err_rod <= err_rod_prox;
            err_jog <= err_jog_prox;
        end
    end

    always_comb begin
        estado_prox  = estado;
        cnt_prox     = cnt;
        rodada_prox  = rodada;
        jogada_prox  = jogada;
        err_en_prox  = err_en;
        err_rod_prox = err_rod;
        err_jog_prox = err_jog;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    err_en_prox  = erro_habilita;
                    err_rod_prox = erro_rodada;
                    err_jog_prox = erro_jogada;
                    rodada_prox  = '0;
                    jogada_prox  = '0;
                    cnt_prox     = CW'(JOGAR_CICLOS - 1);
                    estado_prox  = INICIA;
                end
            end
            INICIA: begin
                if (cnt == '0) begin
                    cnt_prox    = CW'(ESPERA_CICLOS - 1);
                    estado_prox = ESPERA;
                end else begin
                    cnt_prox = cnt - CW'(1);
                end
            end
            ESPERA: begin
                if (fim_jogo) begin
                    estado_prox = FIM;
                end else if (cnt == '0) begin
                    cnt_prox    = CW'(HOLD_CICLOS - 1);
                    estado_prox = PRESSIONA;
                end else begin
                    cnt_prox = cnt - CW'(1);
                end
            end
            PRESSIONA: begin
                if (fim_jogo) begin
                    estado_prox = FIM;
                end else if (cnt == '0) begin
                    cnt_prox    = CW'(GAP_CICLOS - 1);
                    estado_prox = SOLTA;
                end else begin
                    cnt_prox = cnt - CW'(1);
                end
            end
            SOLTA: begin
                // The gap's last cycle chooses the next move directly, so no bookkeeping cycle.
                if (fim_jogo) begin
                    estado_prox = FIM;
                end else if (cnt == '0) begin
                    if (jogada < rodada) begin
                        jogada_prox = jogada + 4'd1;
                        cnt_prox    = CW'(HOLD_CICLOS - 1);
                        estado_prox = PRESSIONA;
                    end else if (rodada < ULTIMA) begin
                        rodada_prox = rodada + 4'd1;
                        jogada_prox = '0;
                        cnt_prox    = CW'(HOLD_CICLOS - 1);
                        estado_prox = PRESSIONA;
                    end else begin
                        estado_prox = FIM;
                    end
                end else begin
                    cnt_prox = cnt - CW'(1);
                end
            end
            FIM: begin
                rodada_prox = '0;
                jogada_prox = '0;
                cnt_prox    = '0;
                estado_prox = OCIOSO;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    always_comb begin
        normal  = 4'b0001 << jogada[1:0];
        injeta  = err_en && (rodada == err_rod) && (jogada == err_jog);
        jogar   = (estado == INICIA);
        ocupado = (estado != OCIOSO);
        pronto  = (estado == FIM);
        botoes  = 4'b0000;
        if (estado == PRESSIONA) begin
            botoes = injeta ? {normal[2:0], normal[3]} : normal;
        end
    end
endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a press-pattern model predicts every output change,
// a monitor pops and compares each change the DUT makes.
module tb_jogador_automatico;
    localparam int N = 16;
    localparam int J = 5;
    localparam int E = 10;
    localparam int H = 5;
    localparam int G = 5;
    localparam int W = 35;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       fim_jogo;
    logic       erro_habilita;
    logic [3:0] erro_rodada;
    logic [3:0] erro_jogada;
    logic       jogar;
    logic [3:0] botoes;
    logic [3:0] rodada;
    logic [3:0] jogada;
    logic       ocupado;
    logic       pronto;

    jogador_automatico #(
        .N_RODADAS    (N),
        .JOGAR_CICLOS (J),
        .ESPERA_CICLOS(E),
        .HOLD_CICLOS  (H),
        .GAP_CICLOS   (G)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .fim_jogo     (fim_jogo),
        .erro_habilita(erro_habilita),
        .erro_rodada  (erro_rodada),
        .erro_jogada  (erro_jogada),
        .jogar        (jogar),
        .botoes       (botoes),
        .rodada       (rodada),
        .jogada       (jogada),
        .ocupado      (ocupado),
        .pronto       (pronto)
    );

    // clock / reset and edge counter: cyc is the index of the latest rising edge
    always #10 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // scoreboard: {edge index[19:0], jogar, botoes, rodada, jogada, ocupado, pronto}
    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;
    int last_pronto = -1;
    int fa_lo = -1, fa_hi = -2, fb_lo = -1, fb_hi = -2;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic [14:0] pack(input bit jg, input logic [3:0] b, input int r,
                                         input int m, input bit oc, input bit pr);
        return {jg, b, 4'(r), 4'(m), oc, pr};
    endfunction

    function automatic bit fim_at(input int e);
        return (e >= fa_lo && e <= fa_hi) || (e >= fb_lo && e <= fb_hi);
    endfunction

    // Reference: lay out the whole play as a per-cycle plan, cut it at abort/reset,
    // then queue only the cycles where the output vector changes.
    task automatic model_run(input int s, input bit een, input int er, input int ej,
                             input int rst, output int end_e);
        logic [14:0] plan[$];
        bit          ab[$];
        logic [14:0] trace[$];
        logic [14:0] prev;
        logic [14:0] v;
        logic [3:0]  b;
        int          cut;
        for (int j = 0; j < J; j++) begin
            plan.push_back(pack(1'b1, 4'b0, 0, 0, 1'b1, 1'b0));
            ab.push_back(1'b0);
        end
        for (int j = 0; j < E; j++) begin
            plan.push_back(pack(1'b0, 4'b0, 0, 0, 1'b1, 1'b0));
            ab.push_back(1'b1);
        end
        for (int r = 0; r < N; r++) begin
            for (int m = 0; m <= r; m++) begin
                b = 4'b0001 << (m % 4);
                if (een && r == er && m == ej) b = {b[2:0], b[3]};
                for (int k = 0; k < H; k++) begin
                    plan.push_back(pack(1'b0, b, r, m, 1'b1, 1'b0));
                    ab.push_back(1'b1);
                end
                for (int k = 0; k < G; k++) begin
                    plan.push_back(pack(1'b0, 4'b0, r, m, 1'b1, 1'b0));
                    ab.push_back(1'b1);
                end
            end
        end
        cut = plan.size();
        for (int i = 1; i < plan.size(); i++) begin
            if (ab[i-1] && fim_at(s + i)) begin
                cut = i;
                break;
            end
        end
        for (int i = 0; i < cut; i++) trace.push_back(plan[i]);
        v = plan[cut-1];
        trace.push_back(pack(1'b0, 4'b0, int'(v[9:6]), int'(v[5:2]), 1'b1, 1'b1));
        trace.push_back('0);
        if (rst > 0 && rst - s < trace.size()) begin
            while (trace.size() > rst - s) void'(trace.pop_back());
            trace.push_back('0);
        end
        prev = '0;
        for (int i = 0; i < trace.size(); i++) begin
            if (trace[i] !== prev) begin
                exp_q.push_back({20'(s + i), trace[i]});
                prev = trace[i];
            end
        end
        end_e = s + trace.size() - 1;
    endtask

    // monitor: every change of the output vector is one observed response
    initial begin
        logic [14:0]  prev;
        logic [14:0]  cur;
        logic [W-1:0] e;
        prev = '0;
        forever begin
            @(negedge clock);
            cur = {jogar, botoes, rodada, jogada, ocupado, pronto};
            if (mon_en && cur !== prev) begin
                if (cur[0] === 1'b1 && prev[0] !== 1'b1) last_pronto = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_change: got %h at edge %0d, expected none", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_change", {20'(cyc), cur}, e);
                end
                prev = cur;
            end
        end
    end

    // driver: one game; offsets are computed from the move timing rules
    task automatic run_game(input bit een, input int er, input int ej, input int abort_d,
                            input bit fim_inicia, input int rst_round, input bit extra_ini,
                            input bit full);
        int s, p, rst, xini, end_e, stop_e;
        s = cyc + 1;
        fa_lo = -1; fa_hi = -2; fb_lo = -1; fb_hi = -2;
        rst = -1; xini = -1; last_pronto = -1;
        if (abort_d > 0) begin
            p = J + E + ((er * (er + 1)) / 2 + ej) * (H + G);
            fa_lo = s + p + abort_d;
            fa_hi = fa_lo + 7;
        end
        if (fim_inicia) begin
            fb_lo = s;
            fb_hi = s + J;
        end
        if (rst_round >= 0) begin
            p = J + E + ((rst_round * (rst_round + 1)) / 2 + $urandom_range(0, rst_round)) * (H + G);
            rst = s + p + 1 + $urandom_range(0, H - 1);
        end
        if (extra_ini) begin
            p = J + E + (3 + $urandom_range(0, 2)) * (H + G);
            xini = s + p + $urandom_range(0, H + G - 1);
        end
        iniciar = 1'b1;
        erro_habilita = een;
        erro_rodada = 4'(er);
        erro_jogada = 4'(ej);
        fim_jogo = fim_at(s);
        model_run(s, een, er, ej, rst, end_e);
        stop_e = end_e;
        if (fa_hi > stop_e) stop_e = fa_hi;
        if (fb_hi > stop_e) stop_e = fb_hi;
        stop_e = stop_e + 3;
        while (cyc < stop_e) begin
            @(negedge clock);
            iniciar = (cyc + 1 == xini);
            erro_habilita = 1'($urandom_range(0, 1));
            erro_rodada = 4'($urandom_range(0, 15));
            erro_jogada = 4'($urandom_range(0, 15));
            fim_jogo = fim_at(cyc + 1);
            reset = (cyc + 1 == rst);
        end
        iniciar = 1'b0;
        fim_jogo = 1'b0;
        reset = 1'b0;
        erro_habilita = 1'b0;
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (full) check("pronto_lat", 64'(last_pronto - s), 64'(J + E + (N * (N + 1) / 2) * (H + G)));
        repeat ($urandom_range(1, 4)) @(negedge clock);
    endtask

    initial begin
        int r, m;
        reset = 1'b1;
        iniciar = 1'b0;
        fim_jogo = 1'b0;
        erro_habilita = 1'b0;
        erro_rodada = 4'd0;
        erro_jogada = 4'd0;
        repeat (3) @(negedge clock);
        check("reset_out", 64'({jogar, botoes, rodada, jogada, ocupado, pronto}), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clock);

        run_game(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 0, 1'b0, -1, 1'b0, 1'b1);
        run_game(1'b1, 4, 2, $urandom_range(1, H + G), 1'b0, -1, 1'b0, 1'b0);
        run_game(1'b1, 0, 0, $urandom_range(1, H + G), 1'b0, -1, 1'b0, 1'b0);
        run_game(1'b1, 9, 1, 0, 1'b0, 3, 1'b0, 1'b0);
        run_game(1'b1, 2, 5, 0, 1'b0, -1, 1'b1, 1'b1);
        r = $urandom_range(0, 15);
        m = $urandom_range(0, r);
        run_game(1'b1, r, m, $urandom_range(1, H + G), 1'b1, -1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            r = $urandom_range(0, 6);
            m = $urandom_range(0, r);
            run_game(1'b1, r, m, $urandom_range(1, H + G), 1'b0, -1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
